// File: rtl/instr_encoder.sv
// ALU instruction encoder with a first-word-fall-through output FIFO.
// Illegal requests (both or neither source selected) are consumed, flagged and counted.
`ifndef REGISTER_TYPE_OPCODE
`define REGISTER_TYPE_OPCODE 2'b01
`endif
`ifndef IMMEDIATE_TYPE_OPCODE
`define IMMEDIATE_TYPE_OPCODE 2'b10
`endif

module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    alu_op,
  input  logic          sel_reg,
  input  logic          sel_const,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    instr,
  output logic          err_illegal,
  output logic [7:0]    illegal_cnt,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          accept;
  logic          legal;
  logic          push;
  logic          pop;
  logic [5:0]    word;

  // Bit 3 is held at zero: the decoder only looks at three ALU-op bits.
  function automatic logic [5:0] encode(input logic is_reg, input logic [2:0] op);
    logic [1:0] opc;
    opc = is_reg ? `REGISTER_TYPE_OPCODE : `IMMEDIATE_TYPE_OPCODE;
    return {opc, 1'b0, op};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign instr     = out_valid ? mem[rd_ptr] : 6'b0;

  assign accept = in_valid & in_ready;
  assign legal  = sel_reg ^ sel_const;
  assign push   = accept & legal;
  assign pop    = out_valid & out_ready;
  assign word   = encode(sel_reg, alu_op);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
      illegal_cnt <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count + CW'(push) - CW'(pop);
      err_illegal <= accept & ~legal;
      if (accept && !legal) illegal_cnt <= sat_inc(illegal_cnt);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
`ifndef REGISTER_TYPE_OPCODE
`define REGISTER_TYPE_OPCODE 2'b01
`endif
`ifndef IMMEDIATE_TYPE_OPCODE
`define IMMEDIATE_TYPE_OPCODE 2'b10
`endif

module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    alu_op = 3'd0;
  logic          sel_reg = 1'b0;
  logic          sel_const = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [5:0]    instr;
  logic          err_illegal;
  logic [7:0]    illegal_cnt;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [5:0] q[$];
  int         m_ill = 0;
  bit         m_err = 1'b0;

  instr_encoder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .sel_reg(sel_reg), .sel_const(sel_const),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .err_illegal(err_illegal), .illegal_cnt(illegal_cnt), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ill = 0;
      m_err = 1'b0;
    end else begin
      bit rdy, do_pop, acc;
      rdy    = (q.size() != DEPTH);
      do_pop = (q.size() != 0) && out_ready;
      acc    = in_valid && rdy;
      if (do_pop) void'(q.pop_front());
      m_err = acc && (sel_reg == sel_const);
      if (acc && sel_reg != sel_const)
        q.push_back({sel_reg ? `REGISTER_TYPE_OPCODE : `IMMEDIATE_TYPE_OPCODE, 1'b0, alu_op});
      if (m_err && m_ill < 255) m_ill++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in_ready",  in_ready,    q.size() != DEPTH);
      check("m_out_valid", out_valid,   q.size() != 0);
      check("m_count",     count,       q.size());
      check("m_instr",     instr,       (q.size() != 0) ? q[0] : 6'b0);
      check("m_err",       err_illegal, m_err);
      check("m_ill_cnt",   illegal_cnt, m_ill);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic r, input logic c);
    in_valid = v; alu_op = op; sel_reg = r; sel_const = c;
  endtask

  logic [2:0] ops25 [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

  initial begin
    #2;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ill_cnt", illegal_cnt, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single legal register request
    drive(1, 3'b101, 1, 0);
    cycle();
    drive(0, 0, 0, 0);
    check("single_valid", out_valid, 1);
    check("single_instr", instr, 6'b010101);
    check("single_count", count, 1);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    check("single_drain", count, 0);

    // Illegal request
    drive(1, 3'b011, 1, 1);
    cycle();
    drive(0, 0, 0, 0);
    check("ill_err", err_illegal, 1);
    check("ill_cnt", illegal_cnt, 1);
    check("ill_count", count, 0);
    check("ill_valid", out_valid, 0);
    cycle();
    check("ill_err_clear", err_illegal, 0);

    // Fill and backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'(i), 0, 1);
      cycle();
    end
    check("full_ready", in_ready, 0);
    check("full_count", count, 4);
    drive(1, 3'd4, 0, 1);
    cycle(); cycle();
    check("full_hold", count, 4);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    check("full_pop_count", count, 3);
    check("full_pop_ready", in_ready, 1);
    check("full_head", instr, 6'b100001);
    cycle();
    drive(0, 0, 0, 0);
    check("fifth_accepted", count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    out_ready = 1'b0;
    check("drained", count, 0);

    // Wrap and order with toggling out_ready
    for (int i = 0; i < 10; i++) begin
      bit done;
      done = 1'b0;
      drive(1, ops25[i], i[0], ~i[0]);
      for (int t = 0; t < 20 && !done; t++) begin
        done = in_ready;
        cycle();
        out_ready = ~out_ready;
        if (count > 4) check("wrap_count_range", count, 4);
      end
      if (!done) check("wrap_accept_timeout", 0, 1);
    end
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    out_ready = 1'b0;
    check("wrap_drained", count, 0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'(i + 2), 1, 0);
      cycle();
    end
    drive(0, 0, 0, 0);
    check("pre_rst_count", count, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ill", illegal_cnt, 0);
    check("mid_rst_instr", instr, 0);
    cycle();
    rst_n = 1'b1;
    drive(1, 3'b110, 1, 0);
    cycle();
    drive(0, 0, 0, 0);
    check("post_rst_instr", instr, 6'b010110);
    check("post_rst_count", count, 1);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;

    // Saturation
    drive(1, 3'd0, 0, 0);
    for (int i = 0; i < 260; i++) begin
      cycle();
      check("sat_err_pulse", err_illegal, 1);
    end
    drive(0, 0, 0, 0);
    check("sat_cnt", illegal_cnt, 255);
    cycle();
    check("sat_err_clear", err_illegal, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drive(0, 0, 0, 0);
    out_ready = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
